// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller
// Converts a 14-bit binary count (0..9999, saturating) to four BCD digits with a
// sequential double-dabble engine. It time-multiplexes the digits onto one BCD
// bus plus active-low digit selects for a 4-digit common-anode FND.
// Optional feature: define FND_LEADING_ZERO_BLANK_EN to blank leading zeros.
// Blanked digits are driven as 4'hF; the ones digit is never blanked.
module fnd_scan_controller #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int SCAN_HZ     = 1000
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [13:0] i_value,
    input  logic        i_load,
    output logic        o_busy,
    output logic [3:0]  o_digit_sel,
    output logic [3:0]  o_bcd
);

    localparam int SCAN_DIV = CLK_FREQ_HZ / SCAN_HZ;
    localparam int PRE_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    generate
        if (SCAN_DIV < 2) begin : g_bad_scan_div
            $error("fnd_scan_controller: SCAN_DIV must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_reg;
    logic [13:0]        bin_reg;
    logic [15:0]        bcd_reg;
    logic [3:0]         bit_cnt_reg;
    logic [15:0]        display_reg;
    logic               busy_reg;
    logic [PRE_W-1:0]   pre_reg;
    logic [1:0]         idx_reg;
    logic [3:0]         sel_reg;
    logic [3:0]         bcd_out_reg;

    logic [15:0]        bcd_adj;
    logic [13:0]        value_sat;
    logic [3:0]         digit_zero;
    logic [3:0]         blank;
    logic               tick;

    // Out-of-range inputs clamp to the largest displayable value.
    assign value_sat = (i_value > 14'd9999) ? 14'd9999 : i_value;

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                        bcd_reg[4*gi +: 4] + 4'd3 :
                                        bcd_reg[4*gi +: 4];
            assign digit_zero[gi] = (display_reg[4*gi +: 4] == 4'd0);
        end
    endgenerate

`ifdef FND_LEADING_ZERO_BLANK_EN
    // A digit blanks when it and every higher digit are zero; ones never blanks.
    assign blank[3] = digit_zero[3];
    generate
        for (genvar gi = 1; gi < 3; gi++) begin : g_blank
            assign blank[gi] = digit_zero[gi] & blank[gi+1];
        end
    endgenerate
    assign blank[0] = 1'b0;
`else
    assign blank = 4'b0000;
    logic unused_zero;
    assign unused_zero = ^digit_zero;
`endif

    assign tick = (pre_reg == PRE_W'(SCAN_DIV - 1));

    // Conversion FSM: capture, 14 shift cycles, then atomic display update.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg   <= ST_IDLE;
            bin_reg     <= '0;
            bcd_reg     <= '0;
            bit_cnt_reg <= '0;
            display_reg <= 16'h0000;
            busy_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (i_load) begin
                        bin_reg     <= value_sat;
                        bcd_reg     <= '0;
                        bit_cnt_reg <= 4'd13;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    bcd_reg <= {bcd_adj[14:0], bin_reg[13]};
                    bin_reg <= {bin_reg[12:0], 1'b0};
                    if (bit_cnt_reg == 4'd0) begin
                        state_reg <= ST_DONE;
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg - 4'd1;
                    end
                end
                ST_DONE: begin
                    display_reg <= bcd_reg;
                    busy_reg    <= 1'b0;
                    state_reg   <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Free-running scan: prescaler tick registers the current digit, then advances.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pre_reg     <= '0;
            idx_reg     <= 2'd0;
            sel_reg     <= 4'b1111;
            bcd_out_reg <= 4'hF;
        end else begin
            if (tick) begin
                pre_reg     <= '0;
                sel_reg     <= ~(4'b0001 << idx_reg);
                bcd_out_reg <= blank[idx_reg] ? 4'hF : display_reg[4*idx_reg +: 4];
                idx_reg     <= idx_reg + 2'd1;
            end else begin
                pre_reg <= pre_reg + PRE_W'(1);
            end
        end
    end

    assign o_busy      = busy_reg;
    assign o_digit_sel = sel_reg;
    assign o_bcd       = bcd_out_reg;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb_fnd_scan_controller
// Directed bench for fnd_scan_controller with SCAN_DIV = 4.
// Expected digit tables depend on FND_LEADING_ZERO_BLANK_EN.
module tb_fnd_scan_controller;

    logic        clk;
    logic        rst_n;
    logic [13:0] value;
    logic        load;
    logic        busy;
    logic [3:0]  digit_sel;
    logic [3:0]  bcd;

    int checks   = 0;
    int failures = 0;

`ifdef FND_LEADING_ZERO_BLANK_EN
    localparam logic [15:0] EXP_ZERO = 16'hFFF0;
    localparam logic [15:0] EXP_7    = 16'hFFF7;
    localparam logic [15:0] EXP_105  = 16'hF105;
`else
    localparam logic [15:0] EXP_ZERO = 16'h0000;
    localparam logic [15:0] EXP_7    = 16'h0007;
    localparam logic [15:0] EXP_105  = 16'h0105;
`endif

    fnd_scan_controller #(
        .CLK_FREQ_HZ(100),
        .SCAN_HZ    (25)
    ) dut (
        .i_clk      (clk),
        .i_reset_n  (rst_n),
        .i_value    (value),
        .i_load     (load),
        .o_busy     (busy),
        .o_digit_sel(digit_sel),
        .o_bcd      (bcd)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One clock: inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy === 1'b1 && n < 40) begin
            step();
            n++;
        end
        check(tag, {15'd0, busy}, 16'd0);
    endtask

    // Guarantees the currently shown digit was registered after any display update.
    task automatic flush();
        for (int i = 0; i < 4; i++) step();
    endtask

    task automatic read_scan(input string tag, input logic [15:0] exp_digits);
        logic [3:0] want;
        for (int d = 0; d < 4; d++) begin
            int n = 0;
            want = ~(4'b0001 << d);
            while (digit_sel !== want && n < 20) begin
                step();
                n++;
            end
            check($sformatf("%s_sel%0d", tag, d), {12'd0, digit_sel}, {12'd0, want});
            check($sformatf("%s_bcd%0d", tag, d), {12'd0, bcd}, {12'd0, exp_digits[4*d +: 4]});
            $display("scan %s digit%0d sel=%b bcd=%h", tag, d, digit_sel, bcd);
        end
    endtask

    task automatic do_load(input logic [13:0] v, output int busy_cnt);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
        busy_cnt = busy ? 1 : 0;
        for (int i = 0; i < 19; i++) begin
            step();
            if (busy === 1'b1) busy_cnt++;
        end
        $display("load value=%0d busy_cycles=%0d", v, busy_cnt);
    endtask

    initial begin
        int bc;
        logic [3:0] exp_sel;
        logic [3:0] exp_bcd;

        rst_n = 1'b0;
        value = '0;
        load  = 1'b0;

        // Reset state
        step();
        step();
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_sel", {12'd0, digit_sel}, 16'h000F);
        check("rst_bcd", {12'd0, bcd}, 16'h000F);

        // Test 1: reset release, first ticks at clocks 4, 8, 12, 16
        rst_n = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c < 4) begin
                exp_sel = 4'b1111;
                exp_bcd = 4'hF;
            end else begin
                exp_sel = ~(4'b0001 << ((c / 4) - 1));
                exp_bcd = EXP_ZERO[4*((c / 4) - 1) +: 4];
            end
            check($sformatf("t1_sel_c%0d", c), {12'd0, digit_sel}, {12'd0, exp_sel});
            check($sformatf("t1_bcd_c%0d", c), {12'd0, bcd}, {12'd0, exp_bcd});
            $display("t1 clk=%0d sel=%b bcd=%h", c, digit_sel, bcd);
        end

        // Test 2: load 1234, busy for exactly 15 clocks
        do_load(14'd1234, bc);
        check("t2_busy_cycles", 16'(bc), 16'd15);
        flush();
        read_scan("t2", 16'h1234);

        // Test 3: saturation of 12000 to 9999
        do_load(14'd12000, bc);
        check("t3_busy_cycles", 16'(bc), 16'd15);
        flush();
        read_scan("t3", 16'h9999);

        // Test 4a: load while busy is dropped
        value = 14'd1234;
        load  = 1'b1;
        step();
        load  = 1'b0;
        for (int i = 0; i < 4; i++) step();
        value = 14'd5678;
        load  = 1'b1;
        step();
        load  = 1'b0;
        check("t4_busy_mid", {15'd0, busy}, 16'd1);
        wait_idle("t4_idle1");
        for (int i = 0; i < 3; i++) step();
        check("t4_no_queue", {15'd0, busy}, 16'd0);
        flush();
        read_scan("t4a", 16'h1234);

        // Test 4b: load in the first idle clock after DONE is accepted
        value = 14'd1111;
        load  = 1'b1;
        step();
        load  = 1'b0;
        wait_idle("t4_idle2");
        value = 14'd5678;
        load  = 1'b1;
        step();
        load  = 1'b0;
        check("t4_accept", {15'd0, busy}, 16'd1);
        wait_idle("t4_idle3");
        flush();
        read_scan("t4b", 16'h5678);

        // Test 5: asynchronous reset during SHIFT
        value = 14'd4321;
        load  = 1'b1;
        step();
        load  = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("t5_busy_pre", {15'd0, busy}, 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_busy_rst", {15'd0, busy}, 16'd0);
        check("t5_sel_rst", {12'd0, digit_sel}, 16'h000F);
        check("t5_bcd_rst", {12'd0, bcd}, 16'h000F);
        $display("t5 reset mid-shift busy=%b sel=%b bcd=%h", busy, digit_sel, bcd);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("t5_busy_after", {15'd0, busy}, 16'd0);
        read_scan("t5", EXP_ZERO);

        // Test 6: leading-zero behaviour
        do_load(14'd7, bc);
        flush();
        read_scan("t6_7", EXP_7);
        do_load(14'd0, bc);
        flush();
        read_scan("t6_0", EXP_ZERO);
        do_load(14'd105, bc);
        flush();
        read_scan("t6_105", EXP_105);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
